// File: rtl/pe_acc_pipe.sv
// -----------------------------------------------------------------------------
// pe_acc_pipe
//   Pipelined signed dot-product accumulator. Each accepted beat carries
//   N_LANES signed lanes. The lanes are sign-extended to ACC_W bits and reduced
//   by a registered binary adder tree of log2(N_LANES) levels. The tree outputs
//   are then folded into a running accumulator. A beat flagged "last" closes
//   the current dot product and presents the sum on out_data/out_valid.
//   All arithmetic wraps modulo 2^ACC_W.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : in_data/in_last carry a beat
//   in_last    : this beat closes the current dot product
//   in_data    : N_LANES lanes of IN_W bits, lane j at [IN_W*j +: IN_W]
//   in_ready   : block accepts a beat this cycle (combinational)
//   out_ready  : consumer takes out_data this cycle
//   out_valid  : out_data holds a completed dot product
//   out_data   : signed completed sum, ACC_W bits
// -----------------------------------------------------------------------------
module pe_acc_pipe #(
    parameter int N_LANES = 32,
    parameter int IN_W    = 32,
    parameter int ACC_W   = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic [N_LANES*IN_W-1:0]  in_data,
    output logic                     in_ready,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [ACC_W-1:0]         out_data
);

    localparam int L = $clog2(N_LANES);

    // The whole pipeline moves together; a pending unread result freezes it.
    logic             advance_s;
    logic [ACC_W-1:0] lane_ext_s [N_LANES];

    // Accumulator / output stage state
    logic [ACC_W-1:0] acc_d, acc_q;
    logic             first_d, first_q;
    logic             out_valid_d, out_valid_q;
    logic [ACC_W-1:0] out_data_d, out_data_q;
    logic [ACC_W-1:0] partial_s;
    logic [ACC_W-1:0] tree_sum_s;
    logic             tree_vld_s;
    logic             tree_last_s;

    // Global advance/handshake
    always_comb begin
        advance_s = !out_valid_q || out_ready;
        in_ready  = advance_s;
    end

    // Sign-extend every lane to accumulator width
    always_comb begin
        for (int j = 0; j < N_LANES; j++) begin
            lane_ext_s[j] = {{(ACC_W-IN_W){in_data[IN_W*j+IN_W-1]}},
                             in_data[IN_W*j +: IN_W]};
        end
    end

    genvar k;
    for (k = 0; k < L; k++) begin : g_lvl
        localparam int CNT = N_LANES >> (k + 1);

        logic [ACC_W-1:0] sum_d [CNT];
        logic [ACC_W-1:0] sum_q [CNT];
        logic             vld_d, vld_q;
        logic             last_d, last_q;

        if (k == 0) begin : g_first
            // First level adds lane pairs straight from the input beat.
            // While advancing, in_ready is 1, so in_valid alone marks acceptance.
            always_comb begin
                for (int i = 0; i < CNT; i++) begin
                    sum_d[i] = lane_ext_s[2*i] + lane_ext_s[2*i+1];
                end
                vld_d  = in_valid;
                last_d = in_valid && in_last;
            end
        end else begin : g_rest
            // Later levels add pairs of the previous level's registers
            always_comb begin
                for (int i = 0; i < CNT; i++) begin
                    sum_d[i] = g_lvl[k-1].sum_q[2*i] + g_lvl[k-1].sum_q[2*i+1];
                end
                vld_d  = g_lvl[k-1].vld_q;
                last_d = g_lvl[k-1].last_q;
            end
        end

        // Tree level register: loads on advance, holds under backpressure
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                last_q <= 1'b0;
                for (int i = 0; i < CNT; i++) begin
                    sum_q[i] <= {ACC_W{1'b0}};
                end
            end else if (advance_s) begin
                vld_q  <= vld_d;
                last_q <= last_d;
                for (int i = 0; i < CNT; i++) begin
                    sum_q[i] <= sum_d[i];
                end
            end else begin
                vld_q  <= vld_q;
                last_q <= last_q;
                for (int i = 0; i < CNT; i++) begin
                    sum_q[i] <= sum_q[i];
                end
            end
        end
    end

    // Tree output taps
    always_comb begin
        tree_sum_s  = g_lvl[L-1].sum_q[0];
        tree_vld_s  = g_lvl[L-1].vld_q;
        tree_last_s = g_lvl[L-1].last_q;
    end

    // Accumulate tree sums; a last result moves to the output register and
    // re-arms "first" so the next dot product starts from zero.
    always_comb begin
        acc_d       = acc_q;
        first_d     = first_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        partial_s   = (first_q ? {ACC_W{1'b0}} : acc_q) + tree_sum_s;
        if (advance_s) begin
            if (tree_vld_s) begin
                if (tree_last_s) begin
                    out_data_d  = partial_s;
                    out_valid_d = 1'b1;
                    acc_d       = {ACC_W{1'b0}};
                    first_d     = 1'b1;
                end else begin
                    acc_d       = partial_s;
                    first_d     = 1'b0;
                    out_valid_d = 1'b0;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Accumulator and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= {ACC_W{1'b0}};
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= {ACC_W{1'b0}};
        end else begin
            acc_q       <= acc_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Registered outputs
    always_comb begin
        out_valid = out_valid_q;
        out_data  = out_data_q;
    end

endmodule

// File: tb/tb_pe_acc_pipe.sv
module tb_pe_acc_pipe;

    localparam int NL = 32;
    localparam int W  = 32;
    localparam int AW = 40;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_last;
    logic [NL*W-1:0]   in_data;
    logic              in_ready;
    logic              out_ready;
    logic              out_valid;
    logic [AW-1:0]     out_data;

    int checks = 0;
    int errors = 0;

    logic signed [AW-1:0] exp_q [$];
    logic signed [AW-1:0] obs_q [$];
    logic signed [AW-1:0] run_sum;

    pe_acc_pipe #(.N_LANES(NL), .IN_W(W), .ACC_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Straight linear sum of sign-extended lanes, wrapping at AW bits
    function automatic logic signed [AW-1:0] beat_sum(input logic [NL*W-1:0] d);
        logic signed [AW-1:0] s;
        s = '0;
        for (int j = 0; j < NL; j++) begin
            s = s + {{(AW-W){d[W*j+W-1]}}, d[W*j +: W]};
        end
        return s;
    endfunction

    // Scoreboard: model accepted beats, record taken results (mid-cycle sampling)
    initial run_sum = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            run_sum = '0;
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                if (in_last) begin
                    exp_q.push_back(run_sum + beat_sum(in_data));
                    run_sum = '0;
                end else begin
                    run_sum = run_sum + beat_sum(in_data);
                end
            end
            if (out_valid && out_ready) obs_q.push_back(out_data);
        end
    end

    task automatic cycle(output bit acc);
        @(negedge clk);
        acc = rst_n && in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [W-1:0] v);
        for (int j = 0; j < NL; j++) in_data[W*j +: W] = v;
    endtask

    task automatic go_idle();
        bit a;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (14) cycle(a);
    endtask

    task automatic test_reset();
        bit a;
        rst_n = 1'b0; in_valid = 1'b1; in_last = 1'b1; set_all(32'd7); out_ready = 1'b0;
        repeat (3) cycle(a);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== {AW{1'b0}}) begin errors++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        in_valid = 1'b0; in_last = 1'b0; rst_n = 1'b1;
        cycle(a);
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_single();
        bit a;
        int n;
        logic signed [AW-1:0] e, o;
        set_all(32'd1); in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
        cycle(a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL single_accept got %0b exp 1", a); end
        in_valid = 1'b0; in_last = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin cycle(a); n++; end
        checks++; if (n !== 6) begin errors++; $display("FAIL single_latency got %0d exp 6", n); end
        checks++; if (out_data !== 40'd32) begin errors++; $display("FAIL single_data got %0d exp 32", $signed(out_data)); end
        cycle(a);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %0b exp 0", out_valid); end
        go_idle();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL single_sb got %0d exp %0d", o, e); end
        end
        checks++; if (exp_q.size() != 0 || obs_q.size() != 0) begin errors++; $display("FAIL single_count got %0d/%0d exp 0/0", exp_q.size(), obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit a;
        logic signed [AW-1:0] e, o;
        out_ready = 1'b1; set_all(32'hFFFF_FFFE);
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1; in_last = (b == 2);
            cycle(a);
        end
        go_idle();
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL b2b_count got %0d exp 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++; if (obs_q[0] !== -40'sd192) begin errors++; $display("FAIL b2b_value got %0d exp -192", obs_q[0]); end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL b2b_sb got %0d exp %0d", o, e); end
        end
        checks++; if (exp_q.size() != 0 || obs_q.size() != 0) begin errors++; $display("FAIL b2b_left got %0d/%0d exp 0/0", exp_q.size(), obs_q.size()); end
    endtask

    task automatic test_stall();
        bit a;
        int b;
        logic [AW-1:0] held;
        logic signed [AW-1:0] e, o;
        b = 0; held = '0;
        for (int c = 0; c < 300; c++) begin
            if (c < 20) out_ready = 1'b0;
            else out_ready = ((c % 3) == 0);
            in_valid = (b < 8); in_last = 1'b1;
            set_all(W'(b + 1));
            if (c == 8) held = out_data;
            if (c > 8 && c < 20) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready c=%0d got %0b exp 0", c, in_ready); end
                checks++; if (out_data !== held || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold c=%0d got %0h/%0b exp %0h/1", c, out_data, out_valid, held); end
            end
            cycle(a);
            if (a) b++;
            if (b == 8 && c > 20 && obs_q.size() == 8) break;
        end
        go_idle();
        checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL stall_count got %0d exp 8", obs_q.size()); end
        for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== AW'(32 * (i + 1))) begin errors++; $display("FAIL stall_order i=%0d got %0d exp %0d", i, obs_q[i], 32 * (i + 1)); end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL stall_sb got %0d exp %0d", o, e); end
        end
        checks++; if (exp_q.size() != 0 || obs_q.size() != 0) begin errors++; $display("FAIL stall_left got %0d/%0d exp 0/0", exp_q.size(), obs_q.size()); end
    endtask

    task automatic test_wrap();
        bit a;
        logic [63:0] full;
        logic signed [AW-1:0] want, e, o;
        full = 64'd9600 * 64'd2147483647;
        want = full[AW-1:0];
        out_ready = 1'b1; set_all(32'h7FFF_FFFF);
        for (int b = 0; b < 300; b++) begin
            in_valid = 1'b1; in_last = (b == 299);
            cycle(a);
        end
        go_idle();
        checks++; if (obs_q.size() != 1 || obs_q[0] !== want) begin errors++; $display("FAIL wrap_value got %0d (n=%0d) exp %0d", (obs_q.size() > 0) ? obs_q[0] : 40'sd0, obs_q.size(), want); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL wrap_sb got %0d exp %0d", o, e); end
        end
        checks++; if (exp_q.size() != 0 || obs_q.size() != 0) begin errors++; $display("FAIL wrap_left got %0d/%0d exp 0/0", exp_q.size(), obs_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit a;
        logic signed [AW-1:0] e, o;
        out_ready = 1'b1; set_all(32'd9);
        in_valid = 1'b1; in_last = 1'b0;
        repeat (2) cycle(a);
        in_valid = 1'b0; rst_n = 1'b0;
        cycle(a);
        rst_n = 1'b1; set_all(32'd5); in_valid = 1'b1; in_last = 1'b1;
        cycle(a);
        go_idle();
        checks++; if (obs_q.size() != 1 || obs_q[0] !== 40'sd160) begin errors++; $display("FAIL rstmid_value got %0d (n=%0d) exp 160", (obs_q.size() > 0) ? obs_q[0] : 40'sd0, obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL rstmid_sb got %0d exp %0d", o, e); end
        end
        checks++; if (exp_q.size() != 0 || obs_q.size() != 0) begin errors++; $display("FAIL rstmid_left got %0d/%0d exp 0/0", exp_q.size(), obs_q.size()); end
    endtask

    task automatic test_random();
        bit a;
        int guard;
        int n_res;
        logic signed [AW-1:0] e, o;
        for (int c = 0; c < 1000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            for (int j = 0; j < NL; j++) in_data[W*j +: W] = $urandom;
            cycle(a);
        end
        in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
        guard = 0; a = 1'b0;
        while (!a && guard < 50) begin cycle(a); guard++; end
        checks++; if (!a) begin errors++; $display("FAIL rand_final_accept got 0 exp 1"); end
        go_idle();
        n_res = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_res++;
            checks++; if (o !== e) begin errors++; $display("FAIL rand_sb n=%0d got %0d exp %0d", n_res, o, e); end
        end
        checks++; if (exp_q.size() != 0 || obs_q.size() != 0 || n_res < 50) begin errors++; $display("FAIL rand_left got %0d/%0d n=%0d exp 0/0", exp_q.size(), obs_q.size(), n_res); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
